// File: rtl/pencoder_42.sv
// 4-to-2 priority encoder (I4 highest, I1 lowest) with registered outputs.
// O2/O1 carry the index of the highest asserted request; V flags that any
// request was present, which is the only thing separating "idle" from "I1".
// Outputs come straight from flops, so they hold steady between edges.
module pencoder_42 (
  input  logic clk,
  input  logic rst,
  input  logic I1,
  input  logic I2,
  input  logic I3,
  input  logic I4,
  output logic O1,
  output logic O2,
  output logic V
);

  typedef struct packed {
    logic [1:0] idx;
    logic       vld;
  } enc_t;

  enc_t enc_d;
  enc_t enc_q;

  // Priority resolve: the first asserted line from the top wins, lower lines are masked.
  always_comb begin
    enc_d = '0;
    if (I4)      enc_d = '{idx: 2'b11, vld: 1'b1};
    else if (I3) enc_d = '{idx: 2'b10, vld: 1'b1};
    else if (I2) enc_d = '{idx: 2'b01, vld: 1'b1};
    else if (I1) enc_d = '{idx: 2'b00, vld: 1'b1};
  end

  // Output register; reset takes precedence over the encoded value.
  always_ff @(posedge clk) begin
    if (rst) enc_q <= '0;
    else     enc_q <= enc_d;
  end

  assign O2 = enc_q.idx[1];
  assign O1 = enc_q.idx[0];
  assign V  = enc_q.vld;

endmodule

// File: tb/tb_pencoder_42.sv
// Directed bench for pencoder_42: a vector table of {rst, I4..I1, expected
// O2,O1,V} applied one per cycle, plus hand-written multi-cycle sequences
// for mid-cycle input changes and reset in the middle of a stream.
module tb_pencoder_42;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic I1 = 1'b0, I2 = 1'b0, I3 = 1'b0, I4 = 1'b0;
  logic O1, O2, V;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] in;   // {I4,I3,I2,I1}
    logic [2:0] exp;  // {O2,O1,V}
  } vec_t;

  vec_t vecs[$];

  pencoder_42 dut (
    .clk(clk), .rst(rst),
    .I1(I1), .I2(I2), .I3(I3), .I4(I4),
    .O1(O1), .O2(O2), .V(V)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {O2, O1, V};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got O2O1V=%b expected %b", name, got, exp);
  endtask

  task automatic drive(input logic r, input logic [3:0] in);
    rst = r;
    {I4, I3, I2, I1} = in;
  endtask

  // Drive on the falling edge, let the rising edge capture, sample 1 later.
  task automatic step(input logic r, input logic [3:0] in, input logic [2:0] exp, input string name);
    @(negedge clk);
    drive(r, in);
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  initial begin
    // reset with every request high must still clear the outputs
    vecs.push_back('{1'b1, 4'b1111, 3'b000});
    // exhaustive sweep 0000..1111, expected values worked by hand
    vecs.push_back('{1'b0, 4'b0000, 3'b000});
    vecs.push_back('{1'b0, 4'b0001, 3'b001});
    vecs.push_back('{1'b0, 4'b0010, 3'b011});
    vecs.push_back('{1'b0, 4'b0011, 3'b011});
    vecs.push_back('{1'b0, 4'b0100, 3'b101});
    vecs.push_back('{1'b0, 4'b0101, 3'b101});
    vecs.push_back('{1'b0, 4'b0110, 3'b101});
    vecs.push_back('{1'b0, 4'b0111, 3'b101});
    vecs.push_back('{1'b0, 4'b1000, 3'b111});
    vecs.push_back('{1'b0, 4'b1001, 3'b111});
    vecs.push_back('{1'b0, 4'b1010, 3'b111});
    vecs.push_back('{1'b0, 4'b1011, 3'b111});
    vecs.push_back('{1'b0, 4'b1100, 3'b111});
    vecs.push_back('{1'b0, 4'b1101, 3'b111});
    vecs.push_back('{1'b0, 4'b1110, 3'b111});
    vecs.push_back('{1'b0, 4'b1111, 3'b111});
    // idle vs I1 only: V is the only difference
    vecs.push_back('{1'b0, 4'b0001, 3'b001});
    vecs.push_back('{1'b0, 4'b0000, 3'b000});
    // reset override, then first edge after release encodes immediately
    vecs.push_back('{1'b1, 4'b1000, 3'b000});
    vecs.push_back('{1'b0, 4'b1000, 3'b111});

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].in, vecs[i].exp, $sformatf("vec%0d in=%b rst=%b", i, vecs[i].in, vecs[i].rst));

    // mid-cycle input change has no effect until the next rising edge
    step(1'b0, 4'b0000, 3'b000, "latency_pre");
    @(negedge clk);
    drive(1'b0, 4'b0100);
    #2;
    check("latency_hold", 3'b000);
    @(posedge clk);
    #1;
    check("latency_after_edge", 3'b101);

    // reset mid-stream: outputs at 101, one reset cycle, then resume
    step(1'b0, 4'b0110, 3'b101, "midrst_before");
    step(1'b1, 4'b0110, 3'b000, "midrst_assert");
    step(1'b0, 4'b0110, 3'b101, "midrst_resume");

    // a raised reset between edges does nothing until the edge
    @(negedge clk);
    drive(1'b1, 4'b0110);
    #2;
    check("rst_sync_hold", 3'b101);
    @(posedge clk);
    #1;
    check("rst_sync_edge", 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
